// File: rtl/vip_sobel_edge_ext_pkg.sv
// vip_sobel_pkg: shared definitions for the parametrised Sobel edge detector.
//   norm_mode_e : magnitude norm select (L2 / L1 / max, code 3 behaves as L2)
//   SOBEL_LAT   : input-to-output latency in clk cycles
//   sobel_*_w   : width helpers for partial sums, L1 norm and L2 norm
package vip_sobel_pkg;

  typedef enum logic [1:0] {
    MODE_L2  = 2'd0,
    MODE_L1  = 2'd1,
    MODE_MAX = 2'd2,
    MODE_RSV = 2'd3
  } norm_mode_e;

  localparam int SOBEL_LAT = 5;

  // Partial sum p_a + 2*p_b + p_c of DW-bit pixels.
  function automatic int sobel_sw(input int dw);
    return dw + 2;
  endfunction

  // |gx| + |gy|.
  function automatic int sobel_l1_w(input int dw);
    return sobel_sw(dw) + 1;
  endfunction

  // |gx|^2 + |gy|^2.
  function automatic int sobel_l2_w(input int dw);
    return 2 * sobel_sw(dw) + 1;
  endfunction

endpackage

// File: rtl/vip_sobel_edge_ext_if.sv
// Video stream bundle for the Sobel detector.
//   per_*  : input luminance stream with vsync/href/clken framing
//   post_* : delayed framing plus edge bit and saturated gradient magnitude
//   master : stream source / result sink (testbench or upstream glue)
//   slave  : the detector
interface vip_sobel_edge_ext_if #(
  parameter int DW = 8
);
  logic          per_frame_vsync;
  logic          per_frame_href;
  logic          per_frame_clken;
  logic [DW-1:0] per_img_y;
  logic          post_frame_vsync;
  logic          post_frame_href;
  logic          post_frame_clken;
  logic          post_img_bit;
  logic [DW-1:0] post_img_mag;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit, post_img_mag
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit, post_img_mag
  );
endinterface

// File: rtl/vip_line_buffer_3x3.sv
// Two-line buffer plus 3x3 window registers (pipeline stage 1).
//   clk, rst_n : pixel clock, async active-low reset (window regs only)
//   shift_en   : advance the window by one column
//   wr_en      : write the current pixel into the line memories
//   wr_addr    : column index; writes/reads at or beyond IMG_W are ignored
//   din        : incoming pixel (bottom row of the window)
//   win_p1_q   : window [row][col], row 0 = oldest line, col 0 = oldest column
module vip_line_buffer_3x3
  import vip_sobel_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 640
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           shift_en,
  input  logic                           wr_en,
  input  logic [$clog2(IMG_W+1)-1:0]     wr_addr,
  input  logic [DW-1:0]                  din,
  output logic [2:0][2:0][DW-1:0]        win_p1_q
);

  localparam int AW  = $clog2(IMG_W + 1);
  localparam int MAW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [DW-1:0]            line_a [IMG_W];  // previous line
  logic [DW-1:0]            line_b [IMG_W];  // line before that
  logic                     in_range;
  logic [MAW-1:0]           idx;
  logic [2:0][DW-1:0]       col_new;
  logic [2:0][2:0][DW-1:0]  win_p1_d;

  always_comb begin
    in_range   = (wr_addr < AW'(IMG_W));
    idx        = wr_addr[MAW-1:0];
    col_new[0] = in_range ? line_b[idx] : '0;
    col_new[1] = in_range ? line_a[idx] : '0;
    col_new[2] = din;
    win_p1_d   = win_p1_q;
    if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win_p1_d[r][0] = win_p1_q[r][1];
        win_p1_d[r][1] = win_p1_q[r][2];
        win_p1_d[r][2] = col_new[r];
      end
    end
  end

  // Reading and writing the same address in one cycle: both memories see
  // the old contents, so line_a cascades into line_b before being replaced.
  always_ff @(posedge clk) begin
    if (wr_en && in_range) begin
      line_a[idx] <= din;
      line_b[idx] <= line_a[idx];
    end
  end

  // ---- stage 1: window register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_p1_q <= '0;
    else        win_p1_q <= win_p1_d;
  end

endmodule

// File: rtl/vip_sobel_edge_ext.sv
// Parametrised Sobel edge detector for the camera luminance path.
//   clk, rst_n : pixel clock, async active-low reset
//   thresh     : edge threshold in gradient-magnitude units (sampled on vsync rise)
//   mode       : norm select, 0 = L2, 1 = L1, 2 = max, 3 = L2 (sampled on vsync rise)
//   vif        : per_* input stream, post_* outputs delayed by SOBEL_LAT cycles;
//                post_img_bit/post_img_mag are 0 outside href and on border pixels
module vip_sobel_edge_ext
  import vip_sobel_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int THR_W = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [THR_W-1:0]     thresh,
  input  logic [1:0]           mode,
  vip_sobel_edge_ext_if.slave  vif
);

  localparam int SW  = sobel_sw(DW);
  localparam int L1W = sobel_l1_w(DW);
  localparam int L2W = sobel_l2_w(DW);
  localparam int CW  = (L2W > 2 * THR_W) ? L2W : 2 * THR_W;
  localparam int CAW = $clog2(IMG_W + 1);
  localparam int RAW = $clog2(IMG_H + 1);
  localparam logic [DW-1:0] MAG_MAX = '1;

  typedef logic [DW-1:0] pix_t;
  typedef logic [SW-1:0] sum_t;

  function automatic sum_t sum121(input pix_t a, input pix_t b, input pix_t c);
    return sum_t'(a) + (sum_t'(b) << 1) + sum_t'(c);
  endfunction

  function automatic sum_t abs_diff(input sum_t a, input sum_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic pix_t sat_mag(input logic [L1W-1:0] v);
    return (v > L1W'(MAG_MAX)) ? MAG_MAX : v[DW-1:0];
  endfunction

  logic                        vsync_q, vsync_d, href_q, href_d;
  logic [CAW-1:0]              col_cnt_q, col_cnt_d;
  logic [RAW-1:0]              row_cnt_q, row_cnt_d;
  logic [THR_W-1:0]            thr_q, thr_d;
  norm_mode_e                  mode_q, mode_d;
  logic [SOBEL_LAT-1:0][2:0]   frm_q, frm_d;
  logic                        vs_rise, hr_fall, vld_p0;
  logic                        vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic                        vld_p3_q, vld_p3_d, vld_p4_q, vld_p4_d;
  logic [2:0][2:0][DW-1:0]     win_p1_q;
  sum_t                        gxp_p2_q, gxp_p2_d, gxn_p2_q, gxn_p2_d;
  sum_t                        gyp_p2_q, gyp_p2_d, gyn_p2_q, gyn_p2_d;
  sum_t                        ax_p3_q, ax_p3_d, ay_p3_q, ay_p3_d;
  logic [L1W-1:0]              l1_p4;
  logic [CW-1:0]               ax_w, ay_w, thr_w, thr_op;
  logic [CW-1:0]               metric_p4_q, metric_p4_d;
  logic                        sq_p4_q, sq_p4_d;
  pix_t                        mag_p4_q, mag_p4_d;
  logic                        bit_p5_q, bit_p5_d;
  pix_t                        mag_p5_q, mag_p5_d;

  vip_line_buffer_3x3 #(
    .DW    (DW),
    .IMG_W (IMG_W)
  ) u_line_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (vif.per_frame_clken),
    .wr_en    (vif.per_frame_clken & vif.per_frame_href),
    .wr_addr  (col_cnt_q),
    .din      (vif.per_img_y),
    .win_p1_q (win_p1_q)
  );

  always_comb begin
    vs_rise = vif.per_frame_vsync & ~vsync_q;
    hr_fall = ~vif.per_frame_href & href_q;
    vsync_d = vif.per_frame_vsync;
    href_d  = vif.per_frame_href;

    col_cnt_d = col_cnt_q;
    if (!vif.per_frame_href)
      col_cnt_d = '0;
    else if (vif.per_frame_clken && (col_cnt_q < CAW'(IMG_W)))
      col_cnt_d = col_cnt_q + CAW'(1);

    row_cnt_d = row_cnt_q;
    if (vs_rise)
      row_cnt_d = '0;
    else if (hr_fall && (row_cnt_q < RAW'(IMG_H)))
      row_cnt_d = row_cnt_q + RAW'(1);

    thr_d  = vs_rise ? thresh : thr_q;
    mode_d = vs_rise ? norm_mode_e'(mode) : mode_q;

    frm_d = {frm_q[SOBEL_LAT-2:0],
             vif.per_frame_vsync, vif.per_frame_href, vif.per_frame_clken};

    // Border mask for the pixel being accepted now; travels with the data.
    vld_p0 = vif.per_frame_href && (row_cnt_q >= RAW'(2)) &&
             (col_cnt_q >= CAW'(2)) && (col_cnt_q < CAW'(IMG_W));
    vld_p1_d = vld_p0;

    // ---- stage 2: row/column sums ----
    vld_p2_d = vld_p1_q;
    gxp_p2_d = sum121(win_p1_q[0][2], win_p1_q[1][2], win_p1_q[2][2]);
    gxn_p2_d = sum121(win_p1_q[0][0], win_p1_q[1][0], win_p1_q[2][0]);
    gyp_p2_d = sum121(win_p1_q[0][0], win_p1_q[0][1], win_p1_q[0][2]);
    gyn_p2_d = sum121(win_p1_q[2][0], win_p1_q[2][1], win_p1_q[2][2]);

    // ---- stage 3: absolute differences ----
    vld_p3_d = vld_p2_q;
    ax_p3_d  = abs_diff(gxp_p2_q, gxn_p2_q);
    ay_p3_d  = abs_diff(gyp_p2_q, gyn_p2_q);

    // ---- stage 4: norm and saturated magnitude ----
    vld_p4_d = vld_p3_q;
    l1_p4    = L1W'(ax_p3_q) + L1W'(ay_p3_q);
    ax_w     = CW'(ax_p3_q);
    ay_w     = CW'(ay_p3_q);
    sq_p4_d  = 1'b0;
    case (mode_q)
      MODE_L1:  metric_p4_d = CW'(l1_p4);
      MODE_MAX: metric_p4_d = (ax_w >= ay_w) ? ax_w : ay_w;
      default: begin
        metric_p4_d = ax_w * ax_w + ay_w * ay_w;
        sq_p4_d     = 1'b1;
      end
    endcase
    mag_p4_d = sat_mag(l1_p4);

    // ---- stage 5: compare and mask ----
    // The L2 norm is compared squared, so the threshold is squared to match.
    thr_w    = CW'(thr_q);
    thr_op   = sq_p4_q ? (thr_w * thr_w) : thr_w;
    bit_p5_d = vld_p4_q & (metric_p4_q >= thr_op);
    mag_p5_d = vld_p4_q ? mag_p4_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      thr_q       <= '1;
      mode_q      <= MODE_L2;
      frm_q       <= '0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      vld_p4_q    <= 1'b0;
      gxp_p2_q    <= '0;
      gxn_p2_q    <= '0;
      gyp_p2_q    <= '0;
      gyn_p2_q    <= '0;
      ax_p3_q     <= '0;
      ay_p3_q     <= '0;
      metric_p4_q <= '0;
      sq_p4_q     <= 1'b0;
      mag_p4_q    <= '0;
      bit_p5_q    <= 1'b0;
      mag_p5_q    <= '0;
    end else begin
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      thr_q       <= thr_d;
      mode_q      <= mode_d;
      frm_q       <= frm_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      vld_p4_q    <= vld_p4_d;
      gxp_p2_q    <= gxp_p2_d;
      gxn_p2_q    <= gxn_p2_d;
      gyp_p2_q    <= gyp_p2_d;
      gyn_p2_q    <= gyn_p2_d;
      ax_p3_q     <= ax_p3_d;
      ay_p3_q     <= ay_p3_d;
      metric_p4_q <= metric_p4_d;
      sq_p4_q     <= sq_p4_d;
      mag_p4_q    <= mag_p4_d;
      bit_p5_q    <= bit_p5_d;
      mag_p5_q    <= mag_p5_d;
    end
  end

  assign vif.post_frame_vsync = frm_q[SOBEL_LAT-1][2];
  assign vif.post_frame_href  = frm_q[SOBEL_LAT-1][1];
  assign vif.post_frame_clken = frm_q[SOBEL_LAT-1][0];
  assign vif.post_img_bit     = bit_p5_q;
  assign vif.post_img_mag     = mag_p5_q;

endmodule

// File: tb/tb_vip_sobel_edge_ext.sv
// Self-checking bench for vip_sobel_edge_ext: directed frames from the test
// plan plus random frames, compared against a frame-array reference model.
module tb_vip_sobel_edge_ext;
  import vip_sobel_pkg::*;

  localparam int DW    = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int THR_W = 11;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [THR_W-1:0] thresh;
  logic [1:0]       mode;

  vip_sobel_edge_ext_if #(.DW(DW)) vif ();

  vip_sobel_edge_ext #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .THR_W (THR_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .thresh (thresh),
    .mode   (mode),
    .vif    (vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vs, hr, ck, bt, mag, pbit, r, c;
  } exp_t;

  exp_t exp_q[$];
  int   frame_m [0:IMG_H][0:IMG_W-1];
  int   m_row, m_col, m_prev_vs, m_prev_hr, m_thr, m_mode;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv,
                       input int r, input int c);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s (row %0d col %0d): got %0d expected %0d", tag, r, c, act, expv);
    end
  endtask

  // Reference: Sobel on the stored frame, window rows r-2..r, cols c-2..c.
  task automatic model_pixel(inout exp_t e);
    int p [3][3];
    int gx, gy, ax, ay, met, lim;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = frame_m[m_row-2+i][m_col-2+j];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[0][0] + 2*p[0][1] + p[0][2]) - (p[2][0] + 2*p[2][1] + p[2][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (m_mode)
      1:       begin met = ax + ay;                lim = m_thr; end
      2:       begin met = (ax > ay) ? ax : ay;    lim = m_thr; end
      default: begin met = ax*ax + ay*ay;          lim = m_thr * m_thr; end
    endcase
    e.bt  = (met >= lim) ? 1 : 0;
    e.mag = (ax + ay > 255) ? 255 : ax + ay;
  endtask

  // One pixel-clock cycle: check the output due now, drive new inputs, predict.
  task automatic step(input int vs, input int hr, input int y, input int thr,
                      input int md, input int pexp);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == SOBEL_LAT) begin
      e = exp_q.pop_front();
      check("post_vsync", vif.post_frame_vsync, e.vs,  e.r, e.c);
      check("post_href",  vif.post_frame_href,  e.hr,  e.r, e.c);
      check("post_clken", vif.post_frame_clken, e.ck,  e.r, e.c);
      check("edge_bit",   vif.post_img_bit,     e.bt,  e.r, e.c);
      check("edge_mag",   vif.post_img_mag,     e.mag, e.r, e.c);
      if (e.pbit >= 0) check("probe_bit", vif.post_img_bit, e.pbit, e.r, e.c);
    end
    vif.per_frame_vsync = (vs != 0);
    vif.per_frame_href  = (hr != 0);
    vif.per_frame_clken = (hr != 0);
    vif.per_img_y       = DW'(y);
    thresh              = THR_W'(thr);
    mode                = 2'(md);

    if (vs != 0 && m_prev_vs == 0) begin
      m_thr  = thr;
      m_mode = md;
      m_row  = 0;
    end else if (hr == 0 && m_prev_hr != 0 && m_row < IMG_H) begin
      m_row++;
    end
    e = '{vs: vs, hr: hr, ck: hr, bt: 0, mag: 0, pbit: pexp, r: m_row, c: m_col};
    if (hr != 0) begin
      if (m_col < IMG_W) begin
        frame_m[m_row][m_col] = y;
        if (m_row >= 2 && m_col >= 2) model_pixel(e);
        m_col++;
      end
    end else begin
      m_col = 0;
    end
    m_prev_vs = vs;
    m_prev_hr = hr;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_vsync", vif.post_frame_vsync, 0, -1, -1);
    check("rst_href",  vif.post_frame_href,  0, -1, -1);
    check("rst_clken", vif.post_frame_clken, 0, -1, -1);
    check("rst_bit",   vif.post_img_bit,     0, -1, -1);
    check("rst_mag",   vif.post_img_mag,     0, -1, -1);
    vif.per_frame_vsync = 1'b0;
    vif.per_frame_href  = 1'b0;
    vif.per_frame_clken = 1'b0;
    vif.per_img_y       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (SOBEL_LAT) exp_q.push_back('{vs: 0, hr: 0, ck: 0, bt: 0, mag: 0, pbit: -1, r: -1, c: -1});
    m_row = 0; m_col = 0; m_prev_vs = 0; m_prev_hr = 0;
    m_thr = (1 << THR_W) - 1; m_mode = 0;
  endtask

  function automatic int pix(input int kind, input int r, input int c);
    int patch [3][3] = '{'{0, 100, 100}, '{0, 0, 100}, '{0, 0, 0}};
    case (kind)
      1:       return 100;
      2:       return (c < 4) ? 0 : 255;
      3:       return (r < 3 && c < 3) ? patch[r][c] : 0;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic run_line(input int kind, input int r, input int len, input int thr,
                          input int md, input int pr, input int pc, input int pexp);
    for (int c = 0; c < len; c++)
      step(0, 1, pix(kind, r, c), thr, md, (r == pr && c == pc) ? pexp : -1);
    repeat (4) step(0, 0, 0, thr, md, -1);
  endtask

  task automatic run_frame(input int md, input int md_mid, input int thr0, input int thr_mid,
                           input int kind, input int nlines, input int long_row,
                           input int pr, input int pc, input int pexp);
    repeat (3) step(0, 0, 0, thr0, md, -1);
    repeat (3) step(1, 0, 0, thr0, md, -1);
    repeat (3) step(0, 0, 0, thr_mid, md_mid, -1);
    for (int r = 0; r < nlines; r++)
      run_line(kind, r, (r == long_row) ? IMG_W + 2 : IMG_W, thr_mid, md_mid, pr, pc, pexp);
  endtask

  initial begin
    vif.per_frame_vsync = 1'b0;
    vif.per_frame_href  = 1'b0;
    vif.per_frame_clken = 1'b0;
    vif.per_img_y       = '0;
    thresh = '0;
    mode   = '0;
    do_reset();

    // Flat frame: no gradient anywhere.
    run_frame(0, 0, 1, 1, 1, IMG_H, -1, 3, 4, 0);
    // Vertical step, L1, thresh 500: edges at output cols 4 and 5.
    run_frame(1, 1, 500, 500, 2, IMG_H, -1, 2, 4, 1);
    // Norm selection on |gx| = |gy| = 300.
    run_frame(0, 0, 424, 424, 3, 3, -1, 2, 2, 1);
    run_frame(0, 0, 425, 425, 3, 3, -1, 2, 2, 0);
    run_frame(1, 1, 600, 600, 3, 3, -1, 2, 2, 1);
    run_frame(1, 1, 601, 601, 3, 3, -1, 2, 2, 0);
    run_frame(2, 2, 300, 300, 3, 3, -1, 2, 2, 1);
    run_frame(2, 2, 301, 301, 3, 3, -1, 2, 2, 0);
    // Threshold shadowing: 1023 stays for this frame (1020 < 1023), 10 next frame.
    run_frame(1, 1, 1023, 10, 2, 4, -1, 2, 4, 0);
    run_frame(1, 1, 10, 10, 2, 4, -1, 2, 4, 1);
    // thresh 0 flags every unmasked pixel; over-long line masks excess pixels.
    run_frame(1, 1, 0, 0, 0, IMG_H, -1, 2, 2, 1);
    run_frame(1, 1, 0, 0, 0, IMG_H, 2, 2, 9, 0);

    // Reset during row 3, then continue lines without a new vsync.
    run_frame(1, 1, 0, 0, 0, 3, -1, -1, -1, -1);
    for (int c = 0; c < 4; c++) step(0, 1, pix(0, 3, c), 0, 1, -1);
    do_reset();
    repeat (2) step(0, 0, 0, 0, 1, -1);
    for (int r = 0; r < 4; r++) run_line(0, r, IMG_W, 0, 1, 1, 5, 0);

    // Random frames with mid-frame thresh/mode changes.
    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1200),
                $urandom_range(0, 2047), 0, IMG_H, (f == 3) ? 1 : -1, -1, -1, -1);

    repeat (SOBEL_LAT + 3) step(0, 0, 0, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vip_sobel_edge_ext.md
# vip_sobel_edge_ext

Parametrised Sobel edge detector for the camera video path. It takes a luminance pixel stream with vsync/href/clken framing and produces a per-pixel edge bit plus a saturated gradient magnitude. Compared with the fixed 8-bit detector, it adds:
- configurable pixel width and line length,
- three selectable magnitude norms,
- frame-synchronous threshold/mode update,
- border masking.

It sits between the Y-extraction stage and the binary-image consumers (overlay, object tracking).

## Interface
- `DW`, 8: pixel width in bits.
- `IMG_W`, 640: active pixels per line; line-buffer depth.
- `IMG_H`, 480: active lines per frame.
- `THR_W`, 11: threshold width.
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `thresh` in `THR_W`: edge threshold, in gradient-magnitude units.
- `mode` in 2: norm select. 0 = L2, 1 = L1, 2 = max, 3 = reserved (acts as 0).
- `per_frame_vsync` in 1: input frame sync.
- `per_frame_href` in 1: input line valid.
- `per_frame_clken` in 1: input pixel strobe.
- `per_img_y` in `DW`: input luminance.
- `post_frame_vsync` out 1: `per_frame_vsync` delayed by 5 cycles.
- `post_frame_href` out 1: `per_frame_href` delayed by 5 cycles.
- `post_frame_clken` out 1: `per_frame_clken` delayed by 5 cycles.
- `post_img_bit` out 1: edge flag. 0 when `post_frame_href` = 0 or the pixel is a border pixel.
- `post_img_mag` out `DW`: min(|gx|+|gy|, 2^DW−1). Same masking as `post_img_bit`.

## Operation
- Sampling: on each `per_frame_vsync` 0→1 edge, capture `thresh` → `thr_q` and `mode` → `mode_q`. Both are stable for the whole frame.
- Reset values of the shadow registers: `thr_q` = all ones, `mode_q` = 0.
- Counters:
  - `col_cnt` increments on `clken`&&`href`, clears while `href` = 0, saturates at `IMG_W`.
  - `row_cnt` increments on each `href` 1→0 edge, clears on vsync 0→1, saturates at `IMG_H`.
- Line buffer:
  - Two line memories of `IMG_W` × `DW`, written only on `clken`&&`href`.
  - Write address is `col_cnt`. Writes are inhibited when `col_cnt` ≥ `IMG_W`.
  - A 3×3 window of column shift registers sits behind the memories.
  - The window presented for input pixel (r,c) is centred on (r−1,c−1).
- Gradients:
  - |gx| = |(p13+2p23+p33) − (p11+2p21+p31)|.
  - |gy| = |(p11+2p12+p13) − (p31+2p32+p33)|.
  - Partial sums are `SW` = `DW`+2 bits, unsigned. The absolute difference is computed as larger minus smaller.
- Decision, all arithmetic unsigned with operands zero-extended to the widest operand:
  - L2: |gx|²+|gy|² (2·`SW`+1 bits) ≥ `thr_q`² (2·`THR_W` bits).
  - L1: |gx|+|gy| (`SW`+1 bits) ≥ `thr_q`.
  - max: max(|gx|,|gy|) ≥ `thr_q`.
- Border mask: the output for input position (r,c) is valid only when r ≥ 2, c ≥ 2 and c < `IMG_W`. Otherwise bit and mag are forced to 0. The mask is pipelined alongside the data.
- Data pipeline: advances every `clk`, not gated by `clken`. Only the line-memory writes and the window shift are gated by `clken`.

## Timing
- Latency is exactly 5 `clk` from `per_*` to `post_*`, for framing, bit and mag alike.
  - Stage 1: window register.
  - Stage 2: row/column sums.
  - Stage 3: absolute differences.
  - Stage 4: norm and saturated magnitude.
  - Stage 5: compare and mask.
- Reset (async): all pipeline regs, counters, delay lines and outputs go to 0. `thr_q`/`mode_q` go to their reset values.
- Reset mid-frame:
  - Outputs are 0 immediately.
  - After release, `row_cnt` = 0, so no edge bit is produced until 2 lines have completed.
  - Line memory contents are don't-care.
- Over-long line (more than `IMG_W` strobes): the excess pixels are not written and are output with bit = 0, mag = 0.
- vsync edge coinciding with a `thresh` change: the value present on that edge is captured.
- `thresh` = 0: every unmasked pixel flags as an edge.

## Structure
- Package `vip_sobel_pkg`:
  - `MODE_L2` = 0, `MODE_L1` = 1, `MODE_MAX` = 2.
  - Pipeline-latency constant `SOBEL_LAT` = 5.
  - Width helpers for `SW`, L1 width and L2 width.
- Sub-module `vip_line_buffer_3x3` (params `DW`, `IMG_W`): two line memories, the write-address handling and the 3×3 window registers (stage 1).
- Top level: counters, threshold shadowing, gradient/norm/compare pipeline, framing delay lines.

## Test plan
- Flat frame: `IMG_W`=8, `IMG_H`=6, all pixels 100, mode 0, thresh 1 → `post_img_bit` = 0 and `post_img_mag` = 0 everywhere; `post_*` framing equals input delayed by 5 cycles.
- Vertical step: cols 0–3 = 0, cols 4–7 = 255, mode 1, thresh 500 → for rows ≥ 2, bit = 1 and mag = 255 at output cols 4 and 5; all else 0; rows 0–1 all 0.
- Norm selection: 3×3 patch giving |gx| = |gy| = 300.
  - mode 0: thresh 424 → 1; thresh 425 → 0.
  - mode 1: thresh 600 → 1; thresh 601 → 0.
  - mode 2: thresh 300 → 1; thresh 301 → 0.
- Threshold shadowing: change thresh from 1023 to 10 mid-frame → no change in the current frame; new value applied from the next vsync 0→1 edge.
- Over-long line: 10 strobes with `IMG_W`=8 → output positions 8 and 9 give bit 0 and mag 0; next line unaffected.
- Reset mid-frame: `rst_n` low during row 3 → all outputs 0 immediately; after release, bit stays 0 until `row_cnt` ≥ 2 of the new frame.
